// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare predictor port arbiter.
package bp_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Widest branch address any arbiter instance may carry; narrower instances zero-extend.
  localparam int unsigned BP_ADDR_MAX_W = 32;

  typedef enum logic [0:0] {
    S_LOOK,
    S_DRAIN
  } arb_state_e;

  typedef struct packed {
    logic [BP_ADDR_MAX_W-1:0] addr;
    logic                     taken;
    logic [6:0]               opcode;
  } bp_outcome_t;

  function automatic logic is_bp_opcode(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JALR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/bp_outcome_fifo.sv
// Synchronous FIFO of resolved branch outcomes; count is pointer difference plus a full bit.
module bp_outcome_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  bp_outcome_t            push_data,
  input  logic                   pop,
  output bp_outcome_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  bp_outcome_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          full_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;

  assign full  = full_q;
  assign empty = !full_q && (wr_ptr_q == rd_ptr_q);
  // A full FIFO has equal pointers, so the full bit alone supplies the MSB.
  assign count = {full_q, wr_ptr_q - rd_ptr_q};
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop && ((wr_ptr_q + 1'b1) == rd_ptr_q)) begin
        full_q <= 1'b1;
      end else if (do_pop && !do_push) begin
        full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/bp_port_arbiter.sv
// Shares the predictor port between IF lookups and buffered EX updates, with a starvation guard.
// Optional BP_ARB_STATS_EN adds saturating drop_cnt / drain_cnt statistics outputs.
module bp_port_arbiter
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lk_req,
  input  logic [ADDR_W-1:0]      lk_addr,
  input  logic [6:0]             lk_opcode,
  output logic                   lk_grant,
  input  logic                   rs_valid,
  input  logic [ADDR_W-1:0]      rs_addr,
  input  logic                   rs_taken,
  input  logic [6:0]             rs_opcode,
  output logic                   rs_ready,
  output logic                   start,
  output logic                   update,
  output logic [ADDR_W-1:0]      branch_address,
  output logic [ADDR_W-1:0]      update_address,
  output logic                   branch_taken,
  output logic [6:0]             opcode,
  output logic [$clog2(DEPTH):0] q_count
`ifdef BP_ARB_STATS_EN
  ,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            drain_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e    state_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          lk_ok;
  logic          rs_ok;
  logic          lk_issue;
  logic          go_drain;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  bp_outcome_t   push_data;
  bp_outcome_t   head;

  assign lk_ok = is_bp_opcode(lk_opcode);
  assign rs_ok = is_bp_opcode(rs_opcode);

  assign lk_grant = !rst && (state_q == S_LOOK) && lk_req;
  // A granted lookup with a foreign opcode still owns the port but does not start the predictor.
  assign lk_issue = lk_grant && lk_ok;
  assign push     = !rst && rs_valid && !fifo_full && rs_ok;

  always_comb begin
    pop = 1'b0;
    if (!rst && !fifo_empty) begin
      pop = (state_q == S_DRAIN) || !lk_req;
    end
  end

  assign push_data.addr   = BP_ADDR_MAX_W'(rs_addr);
  assign push_data.taken  = rs_taken;
  assign push_data.opcode = rs_opcode;

  bp_outcome_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign q_count  = count;
  assign rs_ready = !fifo_full;

  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (lk_grant && !fifo_empty && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign count_next = count + CW'(push) - CW'(pop);
  // Decided on post-edge values so the drain cycle follows the last tolerated lookup directly.
  assign go_drain   = (starve_d == SW'(STARVE_MAX)) || (count_next == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LOOK;
      starve_q       <= '0;
      start          <= 1'b0;
      update         <= 1'b0;
      branch_address <= '0;
      update_address <= '0;
      branch_taken   <= 1'b0;
      opcode         <= '0;
    end else begin
      start  <= lk_issue;
      update <= pop;
      if (lk_issue) begin
        branch_address <= lk_addr;
        opcode         <= lk_opcode;
      end else if (pop) begin
        update_address <= ADDR_W'(head.addr);
        branch_taken   <= head.taken;
        opcode         <= head.opcode;
      end
      unique case (state_q)
        S_LOOK: begin
          starve_q <= starve_d;
          if (go_drain) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          starve_q <= '0;
          state_q  <= S_LOOK;
        end
      endcase
    end
  end

`ifdef BP_ARB_STATS_EN
  logic drop_ev;
  logic drain_ev;

  assign drop_ev  = !rst && rs_valid && rs_ok && fifo_full;
  assign drain_ev = !rst && (state_q == S_LOOK) && go_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (drop_ev && (drop_cnt != 16'hffff)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (drain_ev && (drain_cnt != 16'hffff)) begin
        drain_cnt <= drain_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_port_arbiter.sv
// Directed bench for bp_port_arbiter with a queue-based reference model checked every cycle.
module tb_bp_port_arbiter;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned STARVE_MAX = 3;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ALU  = 7'b0110011;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lk_req;
  logic [ADDR_W-1:0] lk_addr;
  logic [6:0]        lk_opcode;
  logic              lk_grant;
  logic              rs_valid;
  logic [ADDR_W-1:0] rs_addr;
  logic              rs_taken;
  logic [6:0]        rs_opcode;
  logic              rs_ready;
  logic              start;
  logic              update;
  logic [ADDR_W-1:0] branch_address;
  logic [ADDR_W-1:0] update_address;
  logic              branch_taken;
  logic [6:0]        opcode;
  logic [2:0]        q_count;
`ifdef BP_ARB_STATS_EN
  logic [15:0]       drop_cnt;
  logic [15:0]       drain_cnt;
`endif

  bp_port_arbiter #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lk_req        (lk_req),
    .lk_addr       (lk_addr),
    .lk_opcode     (lk_opcode),
    .lk_grant      (lk_grant),
    .rs_valid      (rs_valid),
    .rs_addr       (rs_addr),
    .rs_taken      (rs_taken),
    .rs_opcode     (rs_opcode),
    .rs_ready      (rs_ready),
    .start         (start),
    .update        (update),
    .branch_address(branch_address),
    .update_address(update_address),
    .branch_taken  (branch_taken),
    .opcode        (opcode),
    .q_count       (q_count)
`ifdef BP_ARB_STATS_EN
    ,
    .drop_cnt      (drop_cnt),
    .drain_cnt     (drain_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending outcomes plus a "drain owed" flag.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              taken;
    logic [6:0]        op;
  } ent_t;

  ent_t              mq[$];
  bit                m_drain;
  int                m_starve;
  int                m_drops;
  int                m_drains;
  logic              e_start;
  logic              e_update;
  logic              e_taken;
  logic [ADDR_W-1:0] e_baddr;
  logic [ADDR_W-1:0] e_uaddr;
  logic [6:0]        e_op;

  function automatic bit ok_op(input logic [6:0] o);
    return (o == BR) || (o == JALR) || (o == JAL);
  endfunction

  task automatic model_step();
    bit   grant;
    bit   pop;
    bit   push;
    ent_t h;
    ent_t n;
    if (rst) begin
      mq.delete();
      m_drain  = 1'b0;
      m_starve = 0;
      m_drops  = 0;
      m_drains = 0;
      e_start  = 1'b0;
      e_update = 1'b0;
      e_taken  = 1'b0;
      e_baddr  = '0;
      e_uaddr  = '0;
      e_op     = '0;
      return;
    end
    grant = !m_drain && lk_req;
    pop   = (mq.size() > 0) && (m_drain || !lk_req);
    push  = rs_valid && ok_op(rs_opcode) && (mq.size() < DEPTH);
    if (rs_valid && ok_op(rs_opcode) && (mq.size() == DEPTH) && (m_drops < 65535)) m_drops++;
    e_start  = grant && ok_op(lk_opcode);
    e_update = pop;
    if (e_start) begin
      e_baddr = lk_addr;
      e_op    = lk_opcode;
    end
    if (pop) begin
      h        = mq.pop_front();
      e_uaddr  = h.addr;
      e_taken  = h.taken;
      e_op     = h.op;
      m_starve = 0;
    end else if (grant && (mq.size() > 0)) begin
      m_starve++;
    end
    if (push) begin
      n.addr  = rs_addr;
      n.taken = rs_taken;
      n.op    = rs_opcode;
      mq.push_back(n);
    end
    if (m_drain) begin
      m_drain  = 1'b0;
      m_starve = 0;
    end else if ((m_starve >= STARVE_MAX) || (mq.size() == DEPTH)) begin
      m_drain = 1'b1;
      m_drains++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_grant", lk_grant, !rst && !m_drain && lk_req);
        chk("cyc_start", start, e_start);
        chk("cyc_update", update, e_update);
        chk("cyc_qcount", q_count, mq.size());
        chk("cyc_ready", rs_ready, mq.size() < DEPTH);
        if (e_start) begin
          chk("cyc_baddr", branch_address, e_baddr);
          chk("cyc_op_lk", opcode, e_op);
        end
        if (e_update) begin
          chk("cyc_uaddr", update_address, e_uaddr);
          chk("cyc_taken", branch_taken, e_taken);
          chk("cyc_op_up", opcode, e_op);
        end
`ifdef BP_ARB_STATS_EN
        chk("cyc_drop_cnt", drop_cnt, m_drops);
        chk("cyc_drain_cnt", drain_cnt, m_drains);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input bit lr, input logic [7:0] la, input logic [6:0] lo, input bit rv,
                       input logic [7:0] ra, input bit rt, input logic [6:0] ro);
    lk_req    = lr;
    lk_addr   = la;
    lk_opcode = lo;
    rs_valid  = rv;
    rs_addr   = ra;
    rs_taken  = rt;
    rs_opcode = ro;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    chk("rst_start", start, 0);
    chk("rst_update", update, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_ready", rs_ready, 1);
    chk("rst_grant", lk_grant, 0);
    rst = 1'b0;

    // Lookup: granted same cycle, issued next cycle.
    drive(1, 8'd4, BR, 0, 0, 0, 0);
    chk("lk_grant_same", lk_grant, 1);
    tick();
    chk("lk_start", start, 1);
    chk("lk_baddr", branch_address, 8'd4);
    chk("lk_update", update, 0);

    // Single push: update two cycles later.
    drive(0, 0, 0, 1, 8'd4, 1, BR);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("push_qcount", q_count, 1);
    tick();
    chk("upd_valid", update, 1);
    chk("upd_addr", update_address, 8'd4);
    chk("upd_taken", branch_taken, 1);
    chk("upd_qcount", q_count, 0);

    // Push and pop in the same cycle keep the count.
    drive(0, 0, 0, 1, 8'h11, 0, JALR);
    tick();
    drive(0, 0, 0, 1, 8'h12, 1, JAL);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pp_qcount", q_count, 1);
    chk("pp_uaddr", update_address, 8'h11);
    chk("pp_op", opcode, JALR);
    tick();
    chk("pp_uaddr2", update_address, 8'h12);
    chk("pp_taken2", branch_taken, 1);
    chk("pp_qcount2", q_count, 0);

    // Starvation guard: one queued outcome under continuous lookups.
    drive(1, 8'd8, JAL, 1, 8'h20, 0, BR);
    tick();
    drive(1, 8'd8, JAL, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stv_grant", lk_grant, 1);
      tick();
    end
    chk("stv_block", lk_grant, 0);
    tick();
    chk("stv_regrant", lk_grant, 1);
    chk("stv_update", update, 1);
    chk("stv_uaddr", update_address, 8'h20);
    chk("stv_taken", branch_taken, 0);

    // Fill to full under continuous lookups; the fifth outcome is dropped.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'd8, JAL, 1, 8'(8'h31 + i), i[0], BR);
      tick();
    end
    drive(1, 8'd8, JAL, 1, 8'h35, 1, BR);
    chk("full_qcount", q_count, 4);
    chk("full_ready", rs_ready, 0);
    chk("full_grant", lk_grant, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("full_update", update, 1);
    chk("full_uaddr", update_address, 8'h31);
    chk("full_q3", q_count, 3);
`ifdef BP_ARB_STATS_EN
    chk("drop_cnt", drop_cnt, 1);
    chk("drain_cnt", drain_cnt, 2);
`endif
    repeat (5) tick();
    chk("drained_q", q_count, 0);

    // Foreign opcodes: no push; lookup granted without start.
    drive(0, 0, 0, 1, 8'h40, 1, ALU);
    tick();
    chk("bad_push_q", q_count, 0);
    drive(1, 8'd9, ALU, 0, 0, 0, 0);
    chk("bad_lk_grant", lk_grant, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("bad_lk_start", start, 0);
    tick();

    // Reset in the middle of a drain with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'd10, BR, 1, 8'(8'h50 + i), 1, JALR);
      tick();
    end
    drive(1, 8'd10, BR, 0, 0, 0, 0);
    tick();
    chk("rd_qcount", q_count, 3);
    chk("rd_grant", lk_grant, 0);
    rst = 1'b1;
    tick();
    chk("rr_qcount", q_count, 0);
    chk("rr_update", update, 0);
    chk("rr_ready", rs_ready, 1);
    rst = 1'b0;
    drive(1, 8'd12, JAL, 0, 0, 0, 0);
    chk("rr_grant", lk_grant, 1);
    tick();
    chk("rr_start", start, 1);
    chk("rr_baddr", branch_address, 8'd12);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
